// File: rtl/instr_encoder_loader.sv
// Packs R/lw/sw/beq descriptors into 32-bit MIPS words and streams them into instruction memory.
// Latency: a write strobe appears one cycle after each accepted descriptor; done rises two cycles after the last accept.
// Backpressure: in_ready is low outside a load session and once DEPTH descriptors are taken; offering more then traps in ERR.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_V  = ADDR_W'(BASE);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     pend_q, pend_d;      // descriptors accepted this session
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     count_q, count_d;    // writes actually issued this session
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic                accept;
  logic                new_session;

  // Pure field packing; fields that do not belong to the kind are dropped.
  function automatic logic [31:0] encode(
    input logic [1:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm
  );
    logic [31:0] w;
    case (kind)
      2'b00:   w = {6'b000000, rs, rt, rd, 5'b00000, funct};
      2'b01:   w = {6'b100011, rs, rt, imm};
      2'b10:   w = {6'b101011, rs, rt, imm};
      default: w = {6'b000100, rs, rt, imm};
    endcase
    return w;
  endfunction

  // Ready depends only on registered state, so it never combinationally follows in_valid.
  assign in_ready = (state_q == S_LOAD) && (pend_q < DEPTH_V);
  assign accept   = in_valid && in_ready;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    new_session = 1'b0;

    // A write strobe in flight lands this cycle, so it is counted at this edge.
    if (mem_we_q) begin
      count_d = count_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        new_session = start;
      end
      S_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = encode(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm);
          mem_addr_d  = BASE_V + pend_q[ADDR_W-1:0];
          pend_d      = pend_q + 1'b1;
          if (in_last) begin
            state_d = S_DRAIN;
          end
        end else if (in_valid) begin
          // Valid while not ready in LOAD means the window is full and no last was seen.
          state_d    = S_ERR;
          overflow_d = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d    = S_DONE;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      S_DONE: begin
        new_session = start;
      end
      S_ERR: begin
        new_session = start;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Opening a session overrides any count update from a trailing write.
    if (new_session) begin
      state_d    = S_LOAD;
      pend_d     = '0;
      count_d    = '0;
      mem_addr_d = BASE_V;
      done_d     = 1'b0;
      overflow_d = 1'b0;
      cpu_hold_d = 1'b1;
    end
  end

  // State and registered outputs; reset drops any pending write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_V;
      mem_wdata_q <= '0;
      count_q     <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule
